da_sequencer: RTL
=================

Name: da_sequencer

Overview:
Cycle-level sequencer for the bit-serial distributed-arithmetic (DA) FIR datapath. It accepts one input sample at a time. For each sample it strobes the sample FIFO shift, then walks the DA bit index LSB-to-MSB while driving the accumulator clear, add and sign-subtract controls. It emits a result-valid pulse once the tap FIFO has been primed with TAPS samples, and sits between the input interface and the FIFO/DA-LUT/accumulator datapath.

Parameters:
DATA_WIDTH, 16, sample width in bits; equals the number of bit-serial DA iterations per output (must be >= 2)
TAPS, 8, filter tap count; samples required before outputs are reported valid (must be >= 1)

Ports:
clk  input  1  system clock, all state updates on rising edge
resetn  input  1  asynchronous active-low reset
valid_in  input  1  input sample present this cycle
flush  input  1  synchronous abort; clears sequencing and priming state
ready_out  output  1  sequencer accepts a sample this cycle
enable_FIFO  output  1  one-cycle pulse that shifts the sample into the tap FIFO
acc_clear  output  1  clear DA accumulator
acc_en  output  1  accumulate shifted LUT output this cycle
acc_sub  output  1  subtract instead of add (sign-bit iteration)
bit_sel  output  $clog2(DATA_WIDTH)  bit index used to form the DA LUT address
primed  output  1  TAPS or more samples have entered the FIFO since reset or flush
global_valid_out  output  1  one-cycle pulse: accumulator holds a valid filter output
overrun  output  1  sticky flag: valid_in was asserted while ready_out was 0

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, bit_cnt=0, fill_cnt=0, overrun=0. Outputs are then ready_out=1 and all others 0.
- States: IDLE, LOAD, COMPUTE, DONE. All outputs decode from the registered state and counters only (Moore). There is no combinational path from any input to any output.
- IDLE: ready_out=1. If valid_in=1 and flush=0, go to LOAD; otherwise stay in IDLE.
- LOAD (exactly 1 cycle): enable_FIFO=1, acc_clear=1, bit_sel=0. On exit, bit_cnt<=0 and fill_cnt<=min(fill_cnt+1, TAPS). Next state is COMPUTE.
- COMPUTE (exactly DATA_WIDTH cycles): acc_en=1, bit_sel=bit_cnt, acc_sub=1 only when bit_cnt==DATA_WIDTH-1.
  - bit_cnt increments each cycle.
  - When bit_cnt==DATA_WIDTH-1, bit_cnt wraps to 0 and the next state is DONE.
- DONE (exactly 1 cycle): global_valid_out=1 iff fill_cnt==TAPS. ready_out=1.
  - valid_in=1 and flush=0: go to LOAD (back-to-back sample).
  - Otherwise: go to IDLE.
- Latency: for a sample accepted at edge N, LOAD occupies cycle N+1 and COMPUTE occupies N+2..N+1+DATA_WIDTH. DONE and global_valid_out occur in cycle N+2+DATA_WIDTH.
- Throughput: one sample per DATA_WIDTH+2 cycles.
- primed = (fill_cnt==TAPS). fill_cnt saturates at TAPS and never wraps.
- Acceptance: a sample is accepted only on an edge where ready_out=1 and valid_in=1. valid_in during LOAD or COMPUTE is dropped, not queued, and sets overrun=1. overrun clears only on resetn.
- flush=1 on any edge:
  - Next state is IDLE; bit_cnt and fill_cnt go to 0.
  - flush has priority over valid_in, so no sample is accepted on that edge.
  - flush does not clear overrun.
  - A flush issued during COMPUTE aborts the computation with no global_valid_out.
- Asynchronous reset mid-COMPUTE: outputs return to reset values immediately, with no trailing pulse.
- Undefined state encodings recover to IDLE on the next edge.

Test Plan:
- Reset then single sample: pulse valid_in for 1 cycle at edge 0.
  - enable_FIFO=1 and acc_clear=1 in cycle 1.
  - acc_en=1 for cycles 2..17, with bit_sel counting 0..15 and acc_sub=1 only in cycle 17.
  - DONE in cycle 18 with global_valid_out=0 (fill_cnt=1).
- Priming: feed 8 samples with idle gaps.
  - global_valid_out=0 for samples 1-7 and =1 at the DONE of sample 8.
  - primed rises after the 8th LOAD.
  - Samples 9 and 10 each give a global_valid_out pulse.
- Back-to-back: hold valid_in=1 continuously after priming.
  - enable_FIFO pulses exactly every 18 cycles.
  - global_valid_out pulses every 18 cycles.
  - Sequencing never enters IDLE.
  - overrun=1 is expected, because valid_in is high while ready_out=0.
- Overrun: after reset, assert valid_in at edge 0 and again at edge 5 (mid-COMPUTE).
  - Only one enable_FIFO pulse occurs.
  - overrun=1 from cycle 6 onward.
  - overrun stays set through a subsequent flush and clears only on resetn=0.
- Flush mid-compute: primed, accept a sample, assert flush at bit_cnt=7.
  - State returns to IDLE next cycle and no global_valid_out pulse occurs.
  - fill_cnt=0 and primed=0.
  - The next 7 samples produce no valid pulses.
- Simultaneous flush and valid_in in IDLE: no LOAD, no enable_FIFO, state stays IDLE.
  - Asynchronous resetn asserted mid-COMPUTE forces acc_en=0 and ready_out=1 without waiting for a clock edge.

Source files
------------

// File: rtl/da_sequencer.sv
// Control sequencer for a bit-serial distributed-arithmetic FIR datapath.
// Accepts one sample at a time, strobes the tap FIFO, then walks the DA bit index LSB to MSB.
module da_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int TAPS       = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          valid_in,
  input  logic                          flush,
  output logic                          ready_out,
  output logic                          enable_FIFO,
  output logic                          acc_clear,
  output logic                          acc_en,
  output logic                          acc_sub,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_sel,
  output logic                          primed,
  output logic                          global_valid_out,
  output logic                          overrun
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam int FW = $clog2(TAPS + 1);

  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(TAPS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [BW-1:0] bit_cnt, bit_cnt_next;
  logic [FW-1:0] fill_cnt, fill_cnt_next;
  logic          overrun_next;
  logic          last_bit;
  logic          fill_full;

  assign last_bit  = (bit_cnt == LAST_BIT);
  assign fill_full = (fill_cnt == FILL_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      fill_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      fill_cnt <= fill_cnt_next;
      overrun  <= overrun_next;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    fill_cnt_next = fill_cnt;

    unique case (state)
      IDLE: begin
        if (valid_in) state_next = LOAD;
      end
      LOAD: begin
        bit_cnt_next  = '0;
        fill_cnt_next = fill_full ? fill_cnt : fill_cnt + 1'b1;
        state_next    = COMPUTE;
      end
      COMPUTE: begin
        if (last_bit) begin
          bit_cnt_next = '0;
          state_next   = DONE;
        end else begin
          bit_cnt_next = bit_cnt + 1'b1;
        end
      end
      DONE: begin
        state_next = valid_in ? LOAD : IDLE;
      end
      default: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
      end
    endcase

    // Flush outranks any acceptance decided above, including one from DONE.
    if (flush) begin
      state_next    = IDLE;
      bit_cnt_next  = '0;
      fill_cnt_next = '0;
    end
  end

  // A sample offered while busy is dropped; the flag records the loss until reset.
  assign overrun_next = overrun | (valid_in & ~ready_out);

  always_comb begin
    ready_out        = 1'b0;
    enable_FIFO      = 1'b0;
    acc_clear        = 1'b0;
    acc_en           = 1'b0;
    acc_sub          = 1'b0;
    bit_sel          = '0;
    global_valid_out = 1'b0;

    unique case (state)
      IDLE: ready_out = 1'b1;
      LOAD: begin
        enable_FIFO = 1'b1;
        acc_clear   = 1'b1;
      end
      COMPUTE: begin
        acc_en  = 1'b1;
        acc_sub = last_bit;
        bit_sel = bit_cnt;
      end
      DONE: begin
        ready_out        = 1'b1;
        global_valid_out = fill_full;
      end
      default: ready_out = 1'b0;
    endcase
  end

  assign primed = fill_full;

endmodule
